scan_config_top: RTL and testbench
==================================

// Module: scan_config_top
// PURPOSE
//  Serial scan-configuration block for the analog/RF macros: one shared serial port, three addressed chains.
//  A frame is a 12-bit address plus a 169-bit payload, both shifted in MSB first while scan_en=1.
//  When scan_en falls, the payload's low bits are latched into the addressed chain's static output register.
//  Chains: addr 1 = OSC (53 b), addr 2 = RF_ANLG (169 b), addr 3 = SUPPLY (20 b).
// PARAMETERS
//  ADDR_W     12   address field width
//  PAYLOAD_W  169  payload field width; frame = ADDR_W+PAYLOAD_W = 181 bits
// PORTS
//  scan_clk    in   1  clock; all state updates on posedge
//  scan_reset  in   1  reset, synchronous, active-high
//  scan_en     in   1  shift enable / frame delimiter
//  scan_in     in   1  serial data, sampled on posedge while scan_en=1
//  scan_out    out  1  serial out = MSB of frame shift register (shift[180])
//  SUPPLY_bgr_temp_ctrl, _bgr_vref_ctrl, _current_src_left_ctrl, _current_src_right_ctrl  out 5 each
//  OSC_adc_tune_out, OSC_dig_tune_out, OSC_rtc_tune_out  out 16 each; OSC_adc_reset, _dig_reset, _rtc_reset out 1
//  OSC_debug_mux_ctl  out 2
//  RF_ANLG_tuning_trim_g0 out 8; RF_ANLG_vga_gain_ctrl_q/_i out 10; RF_ANLG_current_dac_vga_i/_q out 6
//  RF_ANLG_bpf_{i,q}_chp0..chp5, RF_ANLG_bpf_{i,q}_clp0..clp2  out 4 each
//  RF_ANLG_vco_cap_coarse out 10; _vco_cap_med out 6; _vco_cap_mod out 8; RF_ANLG_mux_dbg_in/_out out 10
//  RF_ANLG_vco_freq_reset, en_lna, en_mix_i/q, en_tia_i/q, en_buf_i/q, en_vga_i/q, en_bpf_i/q, en_vco_lo  out 1
// BEHAVIOUR
//  - Shift register sr[180:0]: posedge with scan_en=1 -> sr <= {sr[179:0], scan_in}; scan_en=0 -> sr holds.
//  - en_d registers scan_en. Commit on posedge where en_d=1 and scan_en=0 (falling edge of scan_en).
//    Then addr = sr[180:169], p = sr[168:0].
//  - Latency: outputs reflect the new frame one cycle after the first scan_en=0 sample.
//  - Commit by addr:
//    - 3 SUPPLY: bgr_temp=p[19:15], bgr_vref=p[14:10], left=p[9:5], right=p[4:0]
//    - 1 OSC: adc_tune=p[52:37], adc_reset=p[36], dig_tune=p[35:20], dig_reset=p[19], rtc_tune=p[18:3], rtc_reset=p[2], debug_mux=p[1:0]
//    - 2 RF_ANLG (MSB->LSB, contiguous): trim_g0[168:161], vga_q[160:151], vga_i[150:141], dac_i[140:135],
//      dac_q[134:129], i_chp0..5 from [128:125] down to [108:105], i_clp0..2 [104:93], q_chp0..5 [92:69], q_clp0..2 [68:57],
//      cap_coarse[56:47], cap_med[46:41], cap_mod[40:33], vco_freq_reset[32], en_lna[31], mix_i[30], mix_q[29],
//      tia_i[28], tia_q[27], buf_i[26], buf_q[25], vga_i[24], vga_q[23], bpf_i[22], bpf_q[21], vco_lo[20],
//      mux_dbg_in[19:10], mux_dbg_out[9:0]
//  - Unused high payload bits are ignored. Addresses 0 and 4..4095: no output changes.
//  - Only the addressed chain updates; other chains keep their values.
//  - Frames longer than 181 bits: the last 181 bits count. Shorter frames: commit whatever sr holds (no length check).
//  - Reset: sr, en_d and every chain output = 0; scan_out=0. Reset wins over shift/commit in the same cycle.
//    Reset mid-frame discards the partial frame; no commit occurs for it.
//  - scan_en held 0 indefinitely: outputs static, no commit.
// TESTING
//  - Reset 10 cycles -> all outputs 0, scan_out 0.
//  - Frame addr=3, p=804937 (0xC4849) -> bgr_temp=0x18, bgr_vref=0x12, left=0x02, right=0x09; OSC/RF stay 0.
//  - Frame addr=1, p=0x1F4D_8B2C_0FF1_A5 -> each OSC field equals its p slice; SUPPLY keeps prior values.
//  - Frame addr=2, random 169-bit p -> concatenation of all RF outputs in listed order == p; check ~10 vectors.
//  - Frame addr=5 with any p -> no output changes.
//  - scan_reset asserted after 100 of 181 bits, then a full addr=3 frame -> only the second frame commits.
//  - Back-to-back frames separated by one scan_en=0 cycle -> both commit correctly.

Source files
------------

// File: rtl/scan_config_top.sv
// Serial scan-configuration port: one 181-bit frame shift register feeding three
// addressed static configuration chains (OSC, RF_ANLG, SUPPLY) for the analog/RF macros.
module scan_config_top #(
  parameter int ADDR_W    = 12,
  parameter int PAYLOAD_W = 169
) (
  input  logic       scan_clk,
  input  logic       scan_reset,
  input  logic       scan_en,
  input  logic       scan_in,
  output logic       scan_out,

  output logic [4:0] SUPPLY_bgr_temp_ctrl,
  output logic [4:0] SUPPLY_bgr_vref_ctrl,
  output logic [4:0] SUPPLY_current_src_left_ctrl,
  output logic [4:0] SUPPLY_current_src_right_ctrl,

  output logic [15:0] OSC_adc_tune_out,
  output logic [15:0] OSC_dig_tune_out,
  output logic [15:0] OSC_rtc_tune_out,
  output logic        OSC_adc_reset,
  output logic        OSC_dig_reset,
  output logic        OSC_rtc_reset,
  output logic [1:0]  OSC_debug_mux_ctl,

  output logic [7:0] RF_ANLG_tuning_trim_g0,
  output logic [9:0] RF_ANLG_vga_gain_ctrl_q,
  output logic [9:0] RF_ANLG_vga_gain_ctrl_i,
  output logic [5:0] RF_ANLG_current_dac_vga_i,
  output logic [5:0] RF_ANLG_current_dac_vga_q,
  output logic [3:0] RF_ANLG_bpf_i_chp0,
  output logic [3:0] RF_ANLG_bpf_i_chp1,
  output logic [3:0] RF_ANLG_bpf_i_chp2,
  output logic [3:0] RF_ANLG_bpf_i_chp3,
  output logic [3:0] RF_ANLG_bpf_i_chp4,
  output logic [3:0] RF_ANLG_bpf_i_chp5,
  output logic [3:0] RF_ANLG_bpf_i_clp0,
  output logic [3:0] RF_ANLG_bpf_i_clp1,
  output logic [3:0] RF_ANLG_bpf_i_clp2,
  output logic [3:0] RF_ANLG_bpf_q_chp0,
  output logic [3:0] RF_ANLG_bpf_q_chp1,
  output logic [3:0] RF_ANLG_bpf_q_chp2,
  output logic [3:0] RF_ANLG_bpf_q_chp3,
  output logic [3:0] RF_ANLG_bpf_q_chp4,
  output logic [3:0] RF_ANLG_bpf_q_chp5,
  output logic [3:0] RF_ANLG_bpf_q_clp0,
  output logic [3:0] RF_ANLG_bpf_q_clp1,
  output logic [3:0] RF_ANLG_bpf_q_clp2,
  output logic [9:0] RF_ANLG_vco_cap_coarse,
  output logic [5:0] RF_ANLG_vco_cap_med,
  output logic [7:0] RF_ANLG_vco_cap_mod,
  output logic       RF_ANLG_vco_freq_reset,
  output logic       RF_ANLG_en_lna,
  output logic       RF_ANLG_en_mix_i,
  output logic       RF_ANLG_en_mix_q,
  output logic       RF_ANLG_en_tia_i,
  output logic       RF_ANLG_en_tia_q,
  output logic       RF_ANLG_en_buf_i,
  output logic       RF_ANLG_en_buf_q,
  output logic       RF_ANLG_en_vga_i,
  output logic       RF_ANLG_en_vga_q,
  output logic       RF_ANLG_en_bpf_i,
  output logic       RF_ANLG_en_bpf_q,
  output logic       RF_ANLG_en_vco_lo,
  output logic [9:0] RF_ANLG_mux_dbg_in,
  output logic [9:0] RF_ANLG_mux_dbg_out
);

  localparam int FRAME_W  = ADDR_W + PAYLOAD_W;
  localparam int OSC_W    = 53;
  localparam int RF_W     = 169;
  localparam int SUPPLY_W = 20;

  localparam logic [ADDR_W-1:0] ADDR_OSC    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_RF     = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_SUPPLY = ADDR_W'(3);

  logic [FRAME_W-1:0]   shiftReg_q, shiftReg_d;
  logic                 enDly_q, enDly_d;
  logic [SUPPLY_W-1:0]  supplyCfg_q, supplyCfg_d;
  logic [OSC_W-1:0]     oscCfg_q, oscCfg_d;
  logic [RF_W-1:0]      rfCfg_q, rfCfg_d;

  logic                 commit;
  logic [ADDR_W-1:0]    frameAddr;
  logic [PAYLOAD_W-1:0] payload;

  // A frame commits on the first cycle scan_en is sampled low after being high;
  // only the chain whose address matches is loaded, all others hold.
  always_comb begin
    commit      = enDly_q && !scan_en;
    frameAddr   = shiftReg_q[FRAME_W-1 -: ADDR_W];
    payload     = shiftReg_q[PAYLOAD_W-1:0];
    enDly_d     = scan_en;
    shiftReg_d  = shiftReg_q;
    supplyCfg_d = supplyCfg_q;
    oscCfg_d    = oscCfg_q;
    rfCfg_d     = rfCfg_q;
    if (scan_en) begin
      shiftReg_d = {shiftReg_q[FRAME_W-2:0], scan_in};
    end
    if (commit) begin
      case (frameAddr)
        ADDR_OSC:    oscCfg_d    = payload[OSC_W-1:0];
        ADDR_RF:     rfCfg_d     = payload[RF_W-1:0];
        ADDR_SUPPLY: supplyCfg_d = payload[SUPPLY_W-1:0];
        default:     ;
      endcase
    end
  end

  // Reset clears the partial frame and the edge detector, so an interrupted frame never commits.
  always_ff @(posedge scan_clk) begin
    if (scan_reset) begin
      shiftReg_q  <= '0;
      enDly_q     <= 1'b0;
      supplyCfg_q <= '0;
      oscCfg_q    <= '0;
      rfCfg_q     <= '0;
    end else begin
      shiftReg_q  <= shiftReg_d;
      enDly_q     <= enDly_d;
      supplyCfg_q <= supplyCfg_d;
      oscCfg_q    <= oscCfg_d;
      rfCfg_q     <= rfCfg_d;
    end
  end

  assign scan_out = shiftReg_q[FRAME_W-1];

  assign SUPPLY_bgr_temp_ctrl          = supplyCfg_q[19:15];
  assign SUPPLY_bgr_vref_ctrl          = supplyCfg_q[14:10];
  assign SUPPLY_current_src_left_ctrl  = supplyCfg_q[9:5];
  assign SUPPLY_current_src_right_ctrl = supplyCfg_q[4:0];

  assign OSC_adc_tune_out  = oscCfg_q[52:37];
  assign OSC_adc_reset     = oscCfg_q[36];
  assign OSC_dig_tune_out  = oscCfg_q[35:20];
  assign OSC_dig_reset     = oscCfg_q[19];
  assign OSC_rtc_tune_out  = oscCfg_q[18:3];
  assign OSC_rtc_reset     = oscCfg_q[2];
  assign OSC_debug_mux_ctl = oscCfg_q[1:0];

  // RF fields are packed contiguously from the payload MSB downwards.
  assign RF_ANLG_tuning_trim_g0    = rfCfg_q[168:161];
  assign RF_ANLG_vga_gain_ctrl_q   = rfCfg_q[160:151];
  assign RF_ANLG_vga_gain_ctrl_i   = rfCfg_q[150:141];
  assign RF_ANLG_current_dac_vga_i = rfCfg_q[140:135];
  assign RF_ANLG_current_dac_vga_q = rfCfg_q[134:129];
  assign RF_ANLG_bpf_i_chp0        = rfCfg_q[128:125];
  assign RF_ANLG_bpf_i_chp1        = rfCfg_q[124:121];
  assign RF_ANLG_bpf_i_chp2        = rfCfg_q[120:117];
  assign RF_ANLG_bpf_i_chp3        = rfCfg_q[116:113];
  assign RF_ANLG_bpf_i_chp4        = rfCfg_q[112:109];
  assign RF_ANLG_bpf_i_chp5        = rfCfg_q[108:105];
  assign RF_ANLG_bpf_i_clp0        = rfCfg_q[104:101];
  assign RF_ANLG_bpf_i_clp1        = rfCfg_q[100:97];
  assign RF_ANLG_bpf_i_clp2        = rfCfg_q[96:93];
  assign RF_ANLG_bpf_q_chp0        = rfCfg_q[92:89];
  assign RF_ANLG_bpf_q_chp1        = rfCfg_q[88:85];
  assign RF_ANLG_bpf_q_chp2        = rfCfg_q[84:81];
  assign RF_ANLG_bpf_q_chp3        = rfCfg_q[80:77];
  assign RF_ANLG_bpf_q_chp4        = rfCfg_q[76:73];
  assign RF_ANLG_bpf_q_chp5        = rfCfg_q[72:69];
  assign RF_ANLG_bpf_q_clp0        = rfCfg_q[68:65];
  assign RF_ANLG_bpf_q_clp1        = rfCfg_q[64:61];
  assign RF_ANLG_bpf_q_clp2        = rfCfg_q[60:57];
  assign RF_ANLG_vco_cap_coarse    = rfCfg_q[56:47];
  assign RF_ANLG_vco_cap_med       = rfCfg_q[46:41];
  assign RF_ANLG_vco_cap_mod       = rfCfg_q[40:33];
  assign RF_ANLG_vco_freq_reset    = rfCfg_q[32];
  assign RF_ANLG_en_lna            = rfCfg_q[31];
  assign RF_ANLG_en_mix_i          = rfCfg_q[30];
  assign RF_ANLG_en_mix_q          = rfCfg_q[29];
  assign RF_ANLG_en_tia_i          = rfCfg_q[28];
  assign RF_ANLG_en_tia_q          = rfCfg_q[27];
  assign RF_ANLG_en_buf_i          = rfCfg_q[26];
  assign RF_ANLG_en_buf_q          = rfCfg_q[25];
  assign RF_ANLG_en_vga_i          = rfCfg_q[24];
  assign RF_ANLG_en_vga_q          = rfCfg_q[23];
  assign RF_ANLG_en_bpf_i          = rfCfg_q[22];
  assign RF_ANLG_en_bpf_q          = rfCfg_q[21];
  assign RF_ANLG_en_vco_lo         = rfCfg_q[20];
  assign RF_ANLG_mux_dbg_in        = rfCfg_q[19:10];
  assign RF_ANLG_mux_dbg_out       = rfCfg_q[9:0];

endmodule

// File: tb/tb_scan_config_top.sv
// Scoreboard bench for scan_config_top: stimulus pushes expected chain contents per frame,
// a monitor pops and compares them one cycle after each scan_en falling sample.
module tb_scan_config_top;

  logic scanClk = 1'b0;
  logic scanReset, scanEn, scanIn, scanOut;

  logic [4:0]  supTemp, supVref, supLeft, supRight;
  logic [15:0] oscAdcTune, oscDigTune, oscRtcTune;
  logic        oscAdcRst, oscDigRst, oscRtcRst;
  logic [1:0]  oscDbg;
  logic [7:0]  rfTrim;
  logic [9:0]  rfVgaQ, rfVgaI;
  logic [5:0]  rfDacI, rfDacQ;
  logic [3:0]  iChp0, iChp1, iChp2, iChp3, iChp4, iChp5, iClp0, iClp1, iClp2;
  logic [3:0]  qChp0, qChp1, qChp2, qChp3, qChp4, qChp5, qClp0, qClp1, qClp2;
  logic [9:0]  capCoarse;
  logic [5:0]  capMed;
  logic [7:0]  capMod;
  logic        vcoFreqRst, enLna, enMixI, enMixQ, enTiaI, enTiaQ, enBufI, enBufQ;
  logic        enVgaI, enVgaQ, enBpfI, enBpfQ, enVcoLo;
  logic [9:0]  muxIn, muxOut;

  logic [19:0]  obsSupply;
  logic [52:0]  obsOsc;
  logic [168:0] obsRf;

  typedef struct packed {
    logic [19:0]  supply;
    logic [52:0]  osc;
    logic [168:0] rf;
    logic         sout;
  } expEntry_t;

  expEntry_t expQ[$];
  logic [19:0]  modelSupply;
  logic [52:0]  modelOsc;
  logic [168:0] modelRf;
  int totalChecks = 0;
  int passCount   = 0;

  always #5 scanClk = ~scanClk;

  scan_config_top dut (
    .scan_clk(scanClk), .scan_reset(scanReset), .scan_en(scanEn), .scan_in(scanIn), .scan_out(scanOut),
    .SUPPLY_bgr_temp_ctrl(supTemp), .SUPPLY_bgr_vref_ctrl(supVref),
    .SUPPLY_current_src_left_ctrl(supLeft), .SUPPLY_current_src_right_ctrl(supRight),
    .OSC_adc_tune_out(oscAdcTune), .OSC_dig_tune_out(oscDigTune), .OSC_rtc_tune_out(oscRtcTune),
    .OSC_adc_reset(oscAdcRst), .OSC_dig_reset(oscDigRst), .OSC_rtc_reset(oscRtcRst),
    .OSC_debug_mux_ctl(oscDbg),
    .RF_ANLG_tuning_trim_g0(rfTrim), .RF_ANLG_vga_gain_ctrl_q(rfVgaQ), .RF_ANLG_vga_gain_ctrl_i(rfVgaI),
    .RF_ANLG_current_dac_vga_i(rfDacI), .RF_ANLG_current_dac_vga_q(rfDacQ),
    .RF_ANLG_bpf_i_chp0(iChp0), .RF_ANLG_bpf_i_chp1(iChp1), .RF_ANLG_bpf_i_chp2(iChp2),
    .RF_ANLG_bpf_i_chp3(iChp3), .RF_ANLG_bpf_i_chp4(iChp4), .RF_ANLG_bpf_i_chp5(iChp5),
    .RF_ANLG_bpf_i_clp0(iClp0), .RF_ANLG_bpf_i_clp1(iClp1), .RF_ANLG_bpf_i_clp2(iClp2),
    .RF_ANLG_bpf_q_chp0(qChp0), .RF_ANLG_bpf_q_chp1(qChp1), .RF_ANLG_bpf_q_chp2(qChp2),
    .RF_ANLG_bpf_q_chp3(qChp3), .RF_ANLG_bpf_q_chp4(qChp4), .RF_ANLG_bpf_q_chp5(qChp5),
    .RF_ANLG_bpf_q_clp0(qClp0), .RF_ANLG_bpf_q_clp1(qClp1), .RF_ANLG_bpf_q_clp2(qClp2),
    .RF_ANLG_vco_cap_coarse(capCoarse), .RF_ANLG_vco_cap_med(capMed), .RF_ANLG_vco_cap_mod(capMod),
    .RF_ANLG_vco_freq_reset(vcoFreqRst), .RF_ANLG_en_lna(enLna),
    .RF_ANLG_en_mix_i(enMixI), .RF_ANLG_en_mix_q(enMixQ), .RF_ANLG_en_tia_i(enTiaI), .RF_ANLG_en_tia_q(enTiaQ),
    .RF_ANLG_en_buf_i(enBufI), .RF_ANLG_en_buf_q(enBufQ), .RF_ANLG_en_vga_i(enVgaI), .RF_ANLG_en_vga_q(enVgaQ),
    .RF_ANLG_en_bpf_i(enBpfI), .RF_ANLG_en_bpf_q(enBpfQ), .RF_ANLG_en_vco_lo(enVcoLo),
    .RF_ANLG_mux_dbg_in(muxIn), .RF_ANLG_mux_dbg_out(muxOut)
  );

  // Regroup DUT fields into the payload bit order each chain was loaded from.
  assign obsSupply = {supTemp, supVref, supLeft, supRight};
  assign obsOsc    = {oscAdcTune, oscAdcRst, oscDigTune, oscDigRst, oscRtcTune, oscRtcRst, oscDbg};
  assign obsRf     = {rfTrim, rfVgaQ, rfVgaI, rfDacI, rfDacQ,
                      iChp0, iChp1, iChp2, iChp3, iChp4, iChp5, iClp0, iClp1, iClp2,
                      qChp0, qChp1, qChp2, qChp3, qChp4, qChp5, qClp0, qClp1, qClp2,
                      capCoarse, capMed, capMod, vcoFreqRst, enLna, enMixI, enMixQ,
                      enTiaI, enTiaQ, enBufI, enBufQ, enVgaI, enVgaQ, enBpfI, enBpfQ, enVcoLo,
                      muxIn, muxOut};

  task automatic checkOutput(input string name, input logic [168:0] act, input logic [168:0] exp);
    totalChecks++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Shifts extra junk bits, then {addr, p}, drops scan_en for gap cycles; the model tracks the commit.
  task automatic applyStimulus(input logic [11:0] addr, input logic [168:0] p, input int extra, input int gap);
    logic [180:0] frame;
    expEntry_t e;
    frame = {addr, p};
    for (int i = 0; i < extra; i++) begin
      @(negedge scanClk); scanEn = 1'b1; scanIn = 1'($urandom_range(1, 0));
    end
    for (int i = 180; i >= 0; i--) begin
      @(negedge scanClk); scanEn = 1'b1; scanIn = frame[i];
    end
    case (addr)
      12'd1:   modelOsc    = p[52:0];
      12'd2:   modelRf     = p;
      12'd3:   modelSupply = p[19:0];
      default: ;
    endcase
    e.supply = modelSupply; e.osc = modelOsc; e.rf = modelRf; e.sout = addr[11];
    expQ.push_back(e);
    @(negedge scanClk); scanEn = 1'b0; scanIn = 1'b0;
    repeat (gap - 1) @(negedge scanClk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_supply"}, 169'(obsSupply), 169'd0);
    checkOutput({tag, "_osc"},    169'(obsOsc),    169'd0);
    checkOutput({tag, "_rf"},     obsRf,           169'd0);
    checkOutput({tag, "_scanout"}, 169'(scanOut),  169'd0);
  endtask

  // Monitor: a commit is a non-reset edge sampling scan_en low after it was high; compare at the next negedge.
  initial begin : monitor
    logic monPrevEn;
    expEntry_t e;
    bit isCommit;
    monPrevEn = 1'b0;
    forever begin
      @(posedge scanClk);
      isCommit  = !scanReset && monPrevEn && !scanEn;
      monPrevEn = scanReset ? 1'b0 : scanEn;
      if (isCommit) begin
        @(negedge scanClk);
        if (expQ.size() == 0) begin
          totalChecks++;
          $display("[TB] FAIL commit_unexpected: got commit expected none");
        end else begin
          e = expQ.pop_front();
          checkOutput("supply",  169'(obsSupply), 169'(e.supply));
          checkOutput("osc",     169'(obsOsc),    169'(e.osc));
          checkOutput("rf",      obsRf,           e.rf);
          checkOutput("scanout", 169'(scanOut),   169'(e.sout));
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    logic [168:0] p;
    logic [191:0] wide;
    modelSupply = '0; modelOsc = '0; modelRf = '0;
    scanReset = 1'b1; scanEn = 1'b0; scanIn = 1'b0;
    repeat (10) @(negedge scanClk);
    scanReset = 1'b0;
    @(negedge scanClk);
    checkAllZero("reset");

    // SUPPLY: 0xC4849 -> temp 0x18, vref 0x12, left 0x02, right 0x09.
    applyStimulus(12'd3, 169'hC4849, 0, 2);
    checkOutput("supply_fields", 169'({supTemp, supVref, supLeft, supRight}),
                169'({5'h18, 5'h12, 5'h02, 5'h09}));

    applyStimulus(12'd1, 169'h1F4D8B2C0FF1A5, 0, 3);

    p = '1;
    applyStimulus(12'd2, p, 0, 2);
    for (int i = 0; i < 169; i++) p[i] = i[0];
    applyStimulus(12'd2, p, 0, 2);
    for (int v = 0; v < 8; v++) begin
      wide = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      applyStimulus(12'd2, wide[168:0], 0, 2);
    end

    // Unmapped addresses, including one with the frame MSB set so scan_out reads 1.
    applyStimulus(12'd5, 169'h1234_5678_9ABC_DEF0, 0, 2);
    applyStimulus(12'h803, 169'hFFFFF, 0, 2);

    // Over-long frame: only the final 181 bits matter.
    applyStimulus(12'd3, 169'h5A5A5, 7, 2);

    // Reset after 100 bits of a frame; the partial frame must never commit.
    for (int i = 0; i < 100; i++) begin
      @(negedge scanClk); scanEn = 1'b1; scanIn = 1'($urandom_range(1, 0));
    end
    @(negedge scanClk); scanEn = 1'b0; scanReset = 1'b1;
    repeat (3) @(negedge scanClk);
    scanReset = 1'b0;
    modelSupply = '0; modelOsc = '0; modelRf = '0;
    @(negedge scanClk);
    checkAllZero("midreset");
    applyStimulus(12'd3, 169'hABCDE, 0, 2);

    // Back-to-back frames with a single idle cycle between them.
    applyStimulus(12'd1, 169'h0_0001_FFFF_0000_3, 0, 1);
    applyStimulus(12'd3, 169'h13579, 0, 4);

    repeat (5) @(negedge scanClk);
    checkOutput("scoreboard_empty", 169'(expQ.size()), 169'd0);
    $display("%0d/%0d checks passed", passCount, totalChecks);
    $finish;
  end

endmodule
